// File: rtl/univ_shift_reg.sv
// Universal shift register with single-step ops and a counted burst engine.
// Bursts repeat one shift/rotate a latched number of times, then pulse done.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | direct ops under en; a start with a shift/rotate mode arms a burst
// S_SHIFT | one step of the latched mode per edge; all inputs but sin_* ignored
// S_DONE  | single-cycle completion pulse; start is ignored here
module univ_shift_reg #(
   parameter int WIDTH = 8,
   parameter int AMTW  = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_l,
   input  logic             sin_r,
   input  logic             start,
   input  logic [AMTW-1:0]  amt,
   output logic [WIDTH-1:0] q,
   output logic             sout_msb,
   output logic             sout_lsb,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   localparam logic [AMTW-1:0] AMT_MAX = AMTW'(WIDTH);
   localparam logic [AMTW-1:0] AMT_ONE = AMTW'(1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [AMTW-1:0]  cnt_q, cnt_d;
   logic [2:0]       mode_q, mode_d;
   logic [AMTW-1:0]  amt_sat;

   function automatic logic [WIDTH-1:0] apply_op(
      input logic [2:0]       op,
      input logic [WIDTH-1:0] cur,
      input logic [WIDTH-1:0] ld,
      input logic             sl,
      input logic             sr
   );
      logic [WIDTH-1:0] res;
      res = cur;
      case (op)
         3'b001:  res = {cur[WIDTH-2:0], sr};
         3'b010:  res = {sl, cur[WIDTH-1:1]};
         3'b011:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
         3'b100:  res = {cur[0], cur[WIDTH-1:1]};
         3'b101:  res = ld;
         3'b110:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
         3'b111:  res = '0;
         default: res = cur;
      endcase
      return res;
   endfunction

   // hold, load and clear have no meaning as repeated steps, so they never arm a burst
   function automatic logic is_burst(input logic [2:0] op);
      return op inside {3'b001, 3'b010, 3'b011, 3'b100, 3'b110};
   endfunction

   assign amt_sat = (amt > AMT_MAX) ? AMT_MAX : amt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         q_q     <= '0;
         cnt_q   <= '0;
         mode_q  <= '0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
      end
   end

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      unique case (state_q)
         S_IDLE: begin
            if (start && is_burst(mode)) begin
               mode_d  = mode;
               cnt_d   = amt_sat;
               state_d = (amt_sat != '0) ? S_SHIFT : S_DONE;
            end else if (en) begin
               q_d = apply_op(mode, q_q, d, sin_l, sin_r);
            end
         end
         S_SHIFT: begin
            q_d   = apply_op(mode_q, q_q, d, sin_l, sin_r);
            cnt_d = cnt_q - AMT_ONE;
            if (cnt_q == AMT_ONE) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == S_SHIFT);
      done = (state_q == S_DONE);
   end

   assign q        = q_q;
   assign sout_msb = q_q[WIDTH-1];
   assign sout_lsb = q_q[0];

endmodule
